// File: rtl/hdc_pkg.sv
// Shared HDC types: partial-product element, tree row and the projection controller state.
package hdc_pkg;

  localparam int VECTOR_LEN        = 32;
  localparam int NUM_CODEBOOK_BITS = 4;

  typedef logic signed [NUM_CODEBOOK_BITS-1:0] pp_t;
  typedef pp_t [VECTOR_LEN-1:0]                pp_row_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } ctrl_state_t;

endpackage

// File: rtl/bipolar_projection_ctrl_if.sv
// Job request, SRAM read, sum-tree and result handshake bundle of the projection controller.
interface bipolar_projection_ctrl_if
  import hdc_pkg::*;
#(
  parameter int HV_DIM     = 64,
  parameter int MEM_ADDR_W = 8
) ();

  logic                  start_valid;
  logic                  start_ready;
  logic [MEM_ADDR_W-1:0] cfg_base_addr;

  logic                  mem_rd_en;
  logic [MEM_ADDR_W-1:0] mem_rd_addr;
  pp_row_t               mem_rd_data;

  pp_row_t               tree_operands;
  logic                  tree_sign;

  logic                  result_valid;
  logic                  result_ready;
  logic [HV_DIM-1:0]     result_hv;
  logic                  busy;

  // Controller side.
  modport master (
    input  start_valid, cfg_base_addr, mem_rd_data, tree_sign, result_ready,
    output start_ready, mem_rd_en, mem_rd_addr, tree_operands,
           result_valid, result_hv, busy
  );

  // Requester, SRAM and sum-tree side.
  modport slave (
    output start_valid, cfg_base_addr, mem_rd_data, tree_sign, result_ready,
    input  start_ready, mem_rd_en, mem_rd_addr, tree_operands,
           result_valid, result_hv, busy
  );

endinterface

// File: rtl/bipolar_projection_ctrl.sv
// Streams HV_DIM SRAM rows through one external sum tree, one row per cycle, and packs the sign bits.
// Result valid HV_DIM+3 cycles after accept; DONE holds the result until result_ready.
module bipolar_projection_ctrl
  import hdc_pkg::*;
#(
  parameter int HV_DIM     = 64,
  parameter int MEM_ADDR_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  bipolar_projection_ctrl_if.master bus
);

  localparam int IDX_W = (HV_DIM > 1) ? $clog2(HV_DIM) : 1;
  localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(HV_DIM - 1);

  ctrl_state_t           state_q, state_d;
  logic [MEM_ADDR_W-1:0] base_q;
  logic [IDX_W-1:0]      row_q;
  logic                  accept;
  logic                  issue;

  logic                  s1_vld_q, s2_vld_q;
  logic [IDX_W-1:0]      s1_idx_q, s2_idx_q;
  pp_row_t               ops_q;
  logic [HV_DIM-1:0]     hv_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    issue   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start_valid) begin
          accept  = 1'b1;
          state_d = FETCH;
        end
      end
      FETCH: begin
        issue = 1'b1;
        if (row_q == LAST_ROW) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Stage 1 empties one cycle before the final sign is captured.
        if (!s1_vld_q) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.result_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q <= '0;
      row_q  <= '0;
    end else if (accept) begin
      base_q <= bus.cfg_base_addr;
      row_q  <= '0;
    end else if (issue) begin
      row_q  <= row_q + 1'b1;
    end
  end

  // Index pipeline: stage 1 waits for SRAM data, stage 2 waits for the tree sign.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q <= 1'b0;
      s1_idx_q <= '0;
      s2_vld_q <= 1'b0;
      s2_idx_q <= '0;
      ops_q    <= '0;
    end else begin
      s1_vld_q <= issue;
      if (issue) begin
        s1_idx_q <= row_q;
      end
      s2_vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        s2_idx_q <= s1_idx_q;
        ops_q    <= bus.mem_rd_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hv_q <= '0;
    end else if (accept) begin
      hv_q <= '0;
    end else if (s2_vld_q) begin
      hv_q[s2_idx_q] <= bus.tree_sign;
    end
  end

  assign bus.start_ready   = (state_q == IDLE);
  assign bus.mem_rd_en     = issue;
  assign bus.mem_rd_addr   = base_q + MEM_ADDR_W'(row_q);
  assign bus.tree_operands = ops_q;
  assign bus.result_valid  = (state_q == DONE);
  assign bus.result_hv     = hv_q;
  assign bus.busy          = (state_q == FETCH) || (state_q == DRAIN);

endmodule

// File: tb/tb_bipolar_projection_ctrl.sv
// Scoreboard bench: SRAM and sum-tree models around the controller, expected vectors from row sums.
module tb_bipolar_projection_ctrl;
  import hdc_pkg::*;

  localparam int HV_DIM = 64;
  localparam int AW     = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bipolar_projection_ctrl_if #(.HV_DIM(HV_DIM), .MEM_ADDR_W(AW)) bus ();

  bipolar_projection_ctrl #(.HV_DIM(HV_DIM), .MEM_ADDR_W(AW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  pp_row_t           mem [256];
  logic [HV_DIM-1:0] exp_q [$];
  logic [HV_DIM-1:0] last_hv = '0;
  int                n_tests = 0;
  int                n_fail  = 0;
  int                n_done  = 0;
  bit                rdy_random = 1'b0;
  logic              rdy_fixed  = 1'b1;

  function automatic int row_sum(input pp_row_t r);
    int  s;
    pp_t e;
    s = 0;
    for (int j = 0; j < VECTOR_LEN; j++) begin
      e = r[j];
      s += int'(e);
    end
    return s;
  endfunction

  function automatic pp_row_t const_row(input pp_t v);
    pp_row_t r;
    for (int j = 0; j < VECTOR_LEN; j++) r[j] = v;
    return r;
  endfunction

  // Bit i is the sign of the sum of the row at (base + i) mod 256.
  function automatic logic [HV_DIM-1:0] ref_hv(input logic [AW-1:0] base);
    logic [HV_DIM-1:0] hv;
    hv = '0;
    for (int i = 0; i < HV_DIM; i++) begin
      hv[i] = (row_sum(mem[(int'(base) + i) % 256]) < 0);
    end
    return hv;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fill_random();
    for (int a = 0; a < 256; a++) mem[a] = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Environment models: synchronous SRAM and a combinational sign-of-sum tree.
  always @(posedge clk) begin
    if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_rd_addr];
  end
  assign bus.tree_sign = (row_sum(bus.tree_operands) < 0);

  initial begin
    bus.result_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      bus.result_ready = rdy_random ? 1'($urandom_range(0, 1)) : rdy_fixed;
    end
  end

  // Monitor: timing/address checks against the accept point, result pops on handshake.
  initial begin
    int                nneg;
    int                t0;
    int                d;
    bit                active;
    logic [AW-1:0]     base_m;
    logic [AW-1:0]     a_exp;
    logic [HV_DIM-1:0] e;
    nneg = 0; t0 = 0; active = 1'b0; base_m = '0;
    forever begin
      @(negedge clk);
      nneg++;
      if (!rst_n) begin
        active = 1'b0;
        chk("rd_en_in_reset", bus.mem_rd_en, 1'b0);
      end else begin
        if (active) begin
          d = nneg - t0;
          chk("rd_en_timing", bus.mem_rd_en, (d >= 1 && d <= HV_DIM));
          if (d >= 1 && d <= HV_DIM) begin
            a_exp = base_m + AW'(d - 1);
            chk("rd_addr", bus.mem_rd_addr, a_exp);
          end
          chk("busy_timing", bus.busy, (d <= HV_DIM + 2));
          chk("valid_timing", bus.result_valid, (d == HV_DIM + 3));
          if (d >= HV_DIM + 3) active = 1'b0;
        end
        if (bus.start_valid && bus.start_ready) begin
          active = 1'b1;
          t0     = nneg;
          base_m = bus.cfg_base_addr;
        end
        if (bus.result_valid && bus.result_ready) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_result: got %h with no job outstanding", bus.result_hv);
          end else begin
            e = exp_q.pop_front();
            chk("result_hv", bus.result_hv, e);
          end
          last_hv = bus.result_hv;
          n_done++;
        end
      end
    end
  end

  task automatic wait_done(input int tgt);
    for (int i = 0; i < 400 && n_done < tgt; i++) @(posedge clk);
    chk("job_completed", (n_done >= tgt), 1'b1);
  endtask

  task automatic issue_start(input logic [AW-1:0] base);
    @(posedge clk); #1;
    bus.start_valid   = 1'b1;
    bus.cfg_base_addr = base;
    @(posedge clk); #1;
    bus.start_valid   = 1'b0;
    bus.cfg_base_addr = AW'($urandom);
    chk("hv_clear_at_accept", bus.result_hv, '0);
  endtask

  task automatic run_job(input logic [AW-1:0] base);
    int tgt;
    exp_q.push_back(ref_hv(base));
    tgt = n_done + 1;
    issue_start(base);
    wait_done(tgt);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [AW-1:0]     b;
    logic [HV_DIM-1:0] h;
    int                tgt;
    int                k;
    bus.start_valid   = 1'b0;
    bus.cfg_base_addr = '0;
    fill_random();

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_start_ready", bus.start_ready, 1'b1);
    chk("rst_rd_en", bus.mem_rd_en, 1'b0);
    chk("rst_rd_addr", bus.mem_rd_addr, '0);
    chk("rst_valid", bus.result_valid, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_hv", bus.result_hv, '0);
    chk("rst_operands", bus.tree_operands, '0);

    // Alternating +1 / -1 rows.
    for (int a = 0; a < 256; a++) mem[a] = (a % 2 == 0) ? const_row(pp_t'(1)) : const_row(pp_t'(-1));
    run_job(8'h00);
    chk("alternating_hv", last_hv, 64'hAAAA_AAAA_AAAA_AAAA);

    // Tie, most negative and most positive rows.
    fill_random();
    for (int j = 0; j < VECTOR_LEN; j++) mem[0][j] = (j < 16) ? pp_t'(1) : pp_t'(-1);
    mem[1] = const_row(pp_t'(-8));
    mem[2] = const_row(pp_t'(7));
    run_job(8'h00);
    chk("extremes_bits", last_hv[2:0], 3'b010);

    // Backpressure in DONE with an ignored start request.
    fill_random();
    b = AW'($urandom);
    h = ref_hv(b);
    exp_q.push_back(h);
    tgt = n_done + 1;
    rdy_fixed = 1'b0;
    issue_start(b);
    k = 0;
    while (!bus.result_valid && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    chk("bp_valid_seen", bus.result_valid, 1'b1);
    for (int c = 0; c < 10; c++) begin
      chk("bp_hv_stable", bus.result_hv, h);
      chk("bp_start_ready", bus.start_ready, 1'b0);
      chk("bp_valid_held", bus.result_valid, 1'b1);
      bus.start_valid   = (c == 4);
      bus.cfg_base_addr = AW'($urandom);
      @(posedge clk); #1;
    end
    bus.start_valid = 1'b0;
    rdy_fixed = 1'b1;
    @(posedge clk); #1;
    chk("bp_idle_ready", bus.start_ready, 1'b1);
    chk("bp_idle_valid", bus.result_valid, 1'b0);
    wait_done(tgt);
    fill_random();
    run_job(AW'($urandom));

    // Base near the top of the address space wraps to 00.
    fill_random();
    mem[8'hFF] = const_row(pp_t'(7));
    mem[8'h00] = const_row(pp_t'(-8));
    mem[8'h01] = const_row(pp_t'(7));
    run_job(8'hF0);
    chk("wrap_bits", last_hv[17:15], 3'b010);

    // Reset during FETCH at row 20.
    fill_random();
    b = AW'($urandom);
    issue_start(b);
    repeat (20) @(posedge clk);
    #2;
    chk("pre_reset_rd_en", bus.mem_rd_en, 1'b1);
    chk("pre_reset_addr", bus.mem_rd_addr, AW'(b + 8'd20));
    rst_n = 1'b0;
    #1;
    chk("arst_rd_en", bus.mem_rd_en, 1'b0);
    chk("arst_rd_addr", bus.mem_rd_addr, '0);
    chk("arst_start_ready", bus.start_ready, 1'b1);
    chk("arst_busy", bus.busy, 1'b0);
    chk("arst_valid", bus.result_valid, 1'b0);
    chk("arst_hv", bus.result_hv, '0);
    chk("arst_operands", bus.tree_operands, '0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_q.delete();
    run_job(AW'($urandom));

    // Random jobs under random result backpressure.
    rdy_random = 1'b1;
    for (int n = 0; n < 4; n++) begin
      fill_random();
      run_job(AW'($urandom));
    end
    rdy_random = 1'b0;
    repeat (4) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
